// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux select arbiter: FSM state encoding, sel polarity
// constants and the round-robin arbitration rule used by IDLE and GUARD.
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  typedef enum logic {
    LAST_B = 1'b0,
    LAST_A = 1'b1
  } last_e;

  // The datapath mux computes y = sel ? a : b, so these must stay in step with it.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  function automatic state_e arbitrate(input logic req_a, input logic req_b,
                                       input last_e last);
    state_e nxt;
    nxt = ST_IDLE;
    unique case ({req_a, req_b})
      2'b10:   nxt = ST_GNT_A;
      2'b01:   nxt = ST_GNT_B;
      2'b11:   nxt = (last == LAST_A) ? ST_GNT_B : ST_GNT_A;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic is_grant(input state_e s);
    return (s == ST_GNT_A) || (s == ST_GNT_B);
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two requesters and the mux select arbiter.
// master = requester side, slave = arbiter side.
interface mux_sel_arbiter_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             req_a;
  logic             req_b;
  logic             sel;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic [CNT_W-1:0] switch_cnt;

  modport master (
    output req_a,
    output req_b,
    input  sel,
    input  gnt_a,
    input  gnt_b,
    input  busy,
    input  switch_cnt
  );

  modport slave (
    input  req_a,
    input  req_b,
    output sel,
    output gnt_a,
    output gnt_b,
    output busy,
    output switch_cnt
  );

endinterface

// File: rtl/mux_sel_arbiter_dwell_counter.sv
// Dwell counter for one grant: cleared on grant entry, counts while the grant is
// held, saturates at HOLD_CYCLES; done flags that the minimum hold has been met.
module dwell_counter #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < HOLD_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q >= HOLD_LAST);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2:1 data mux select line, with a minimum grant
// dwell and a one-cycle guard gap so sel never moves under an active grant.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  last_e            last_q, last_d;
  logic             sel_q, sel_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] switch_cnt_q, switch_cnt_d;

  logic             dwell_clr;
  logic             dwell_en;
  logic             dwell_done;
  logic [CNT_W-1:0] dwell_cnt;

  dwell_counter #(
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dwell_clr),
    .en    (dwell_en),
    .cnt   (dwell_cnt),
    .done  (dwell_done)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d      = state_q;
    last_d       = last_q;
    sel_d        = sel_q;
    switch_cnt_d = switch_cnt_q;
    dwell_clr    = 1'b0;
    dwell_en     = 1'b0;

    unique case (state_q)
      ST_GNT_A: begin
        dwell_en = 1'b1;
        // Release once the hold is met if A is done or B is waiting.
        if (dwell_done && (!bus.req_a || bus.req_b)) state_d = ST_GUARD;
      end
      ST_GNT_B: begin
        dwell_en = 1'b1;
        if (dwell_done && (!bus.req_b || bus.req_a)) state_d = ST_GUARD;
      end
      default: begin
        state_d = arbitrate(bus.req_a, bus.req_b, last_q);
      end
    endcase

    // Grant entry is the only place sel, last and the switch counter change.
    if (!is_grant(state_q) && is_grant(state_d)) begin
      dwell_clr = 1'b1;
      if (state_d == ST_GNT_A) begin
        sel_d  = SEL_A;
        last_d = LAST_A;
      end else begin
        sel_d  = SEL_B;
        last_d = LAST_B;
      end
      if (switch_cnt_q != '1) switch_cnt_d = switch_cnt_q + 1'b1;
    end

    gnt_a_d = (state_d == ST_GNT_A);
    gnt_b_d = (state_d == ST_GNT_B);
    busy_d  = gnt_a_d | gnt_b_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_B;
      sel_q        <= SEL_B;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      switch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      busy_q       <= busy_d;
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.busy       = busy_q;
  assign bus.switch_cnt = switch_cnt_q;

  a_one_hot_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt_a_q && gnt_b_q));
  a_sel_follows_a: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_a_q |-> (sel_q == SEL_A));
  a_sel_follows_b: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_b_q |-> (sel_q == SEL_B));
  a_dwell_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    dwell_cnt <= CNT_W'(HOLD_CYCLES));

endmodule
